// File: rtl/usbf_ep_fifo_pkg.sv
// usbf_ep_fifo_pkg: shared endpoint FIFO configuration and types.
// Config macros (mirroring usbf_cfg_defs.v): USB_EP_NUM, USB_EP0_DATA_DATA_W, USB_EP_FIFO_DEPTH.
// Optional build macro used by the FIFO files: USBF_FIFO_LEVEL_EN.
`ifndef USB_EP_NUM
`define USB_EP_NUM 4
`endif
`ifndef USB_EP0_DATA_DATA_W
`define USB_EP0_DATA_DATA_W 8
`endif
`ifndef USB_EP_FIFO_DEPTH
`define USB_EP_FIFO_DEPTH 64
`endif

package usbf_ep_fifo_pkg;

    localparam int EP_NUM     = `USB_EP_NUM;
    localparam int DATA_W     = `USB_EP0_DATA_DATA_W;
    localparam int FIFO_DEPTH = `USB_EP_FIFO_DEPTH;

    // Per-cycle request seen by one FIFO.
    typedef struct packed {
        logic push;
        logic pop;
        logic flush;
    } fifo_req_t;

endpackage

// File: rtl/usbf_ep_fifo_if.sv
// usbf_ep_fifo_if: endpoint-side and CSR-side FIFO signals for all endpoints.
// slave = FIFO block, master = EPU/CSR side. USBF_FIFO_LEVEL_EN adds level outputs.
interface usbf_ep_fifo_if
    import usbf_ep_fifo_pkg::*;
#(
    parameter int N     = EP_NUM,
    parameter int DW    = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
);
    logic [N-1:0]    mem_ep_data_wt_req_i;
    logic [DW*N-1:0] mem_ep_rx_data_i;
    logic [N-1:0]    mem_ep_rx_full_o;
    logic [N-1:0]    mem_ep_data_rd_req_i;
    logic [DW*N-1:0] mem_ep_tx_data_o;
    logic [N-1:0]    mem_ep_tx_empty_o;
    logic [N-1:0]    csr_ep_rx_rd_i;
    logic [DW*N-1:0] csr_ep_rx_data_o;
    logic [N-1:0]    csr_ep_rx_empty_o;
    logic [N-1:0]    csr_ep_rx_flush_i;
    logic [N-1:0]    csr_ep_tx_wr_i;
    logic [DW*N-1:0] csr_ep_tx_data_i;
    logic [N-1:0]    csr_ep_tx_full_o;
    logic [N-1:0]    csr_ep_tx_flush_i;
`ifdef USBF_FIFO_LEVEL_EN
    localparam int LW = $clog2(DEPTH) + 1;
    logic [LW*N-1:0] csr_ep_rx_level_o;
    logic [LW*N-1:0] csr_ep_tx_level_o;
`endif

    modport slave (
        input  mem_ep_data_wt_req_i, mem_ep_rx_data_i,
        input  mem_ep_data_rd_req_i,
        input  csr_ep_rx_rd_i, csr_ep_rx_flush_i,
        input  csr_ep_tx_wr_i, csr_ep_tx_data_i, csr_ep_tx_flush_i,
        output mem_ep_rx_full_o, mem_ep_tx_data_o, mem_ep_tx_empty_o,
        output csr_ep_rx_data_o, csr_ep_rx_empty_o, csr_ep_tx_full_o
`ifdef USBF_FIFO_LEVEL_EN
        , output csr_ep_rx_level_o, csr_ep_tx_level_o
`endif
    );

    modport master (
        output mem_ep_data_wt_req_i, mem_ep_rx_data_i,
        output mem_ep_data_rd_req_i,
        output csr_ep_rx_rd_i, csr_ep_rx_flush_i,
        output csr_ep_tx_wr_i, csr_ep_tx_data_i, csr_ep_tx_flush_i,
        input  mem_ep_rx_full_o, mem_ep_tx_data_o, mem_ep_tx_empty_o,
        input  csr_ep_rx_data_o, csr_ep_rx_empty_o, csr_ep_tx_full_o
`ifdef USBF_FIFO_LEVEL_EN
        , input csr_ep_rx_level_o, csr_ep_tx_level_o
`endif
    );

endinterface

// File: rtl/usbf_sync_fifo.sv
// usbf_sync_fifo: single first-word-fall-through FIFO with flush.
// Ports: push/push_data/full, pop/pop_data/empty, flush; level when USBF_FIFO_LEVEL_EN.
module usbf_sync_fifo
    import usbf_ep_fifo_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    parameter  int DW    = DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          full,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          empty,
    input  logic          flush
`ifdef USBF_FIFO_LEVEL_EN
    , output logic [AW:0] level
`endif
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          push_ok, pop_ok;
    fifo_req_t     req;

    assign req = '{push: push, pop: pop, flush: flush};

    always_comb begin
        pop_ok   = req.pop && !empty_q;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_ok  = req.push && (!full_q || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (req.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage has no reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push_ok && !req.flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty    = empty_q;
    assign full     = full_q;
`ifdef USBF_FIFO_LEVEL_EN
    assign level    = cnt_q;
`endif

endmodule

// File: rtl/usbf_ep_fifo.sv
// usbf_ep_fifo: RX and TX FWFT FIFOs for every endpoint, all on phy_clk_i.
// Ports: phy_clk_i, rstn_i, bus (usbf_ep_fifo_if.slave). Optional: USBF_FIFO_LEVEL_EN.
module usbf_ep_fifo
    import usbf_ep_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int DW    = DATA_W
) (
    input  logic           phy_clk_i,
    input  logic           rstn_i,
    usbf_ep_fifo_if.slave  bus
);

`ifdef USBF_FIFO_LEVEL_EN
    localparam int LW = $clog2(DEPTH) + 1;
`endif

    for (genvar i = 0; i < EP_NUM; i++) begin : g_ep
        logic          rx_full, rx_empty;
        logic          tx_full, tx_empty;
        logic [DW-1:0] rx_head, tx_head;
`ifdef USBF_FIFO_LEVEL_EN
        logic [LW-1:0] rx_lvl, tx_lvl;
`endif

        // RX: endpoint writes, CPU reads.
        usbf_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx (
            .clk       (phy_clk_i),
            .rst_n     (rstn_i),
            .push      (bus.mem_ep_data_wt_req_i[i]),
            .push_data (bus.mem_ep_rx_data_i[i*DW +: DW]),
            .full      (rx_full),
            .pop       (bus.csr_ep_rx_rd_i[i]),
            .pop_data  (rx_head),
            .empty     (rx_empty),
            .flush     (bus.csr_ep_rx_flush_i[i])
`ifdef USBF_FIFO_LEVEL_EN
            , .level   (rx_lvl)
`endif
        );

        // TX: CPU writes, endpoint reads.
        usbf_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx (
            .clk       (phy_clk_i),
            .rst_n     (rstn_i),
            .push      (bus.csr_ep_tx_wr_i[i]),
            .push_data (bus.csr_ep_tx_data_i[i*DW +: DW]),
            .full      (tx_full),
            .pop       (bus.mem_ep_data_rd_req_i[i]),
            .pop_data  (tx_head),
            .empty     (tx_empty),
            .flush     (bus.csr_ep_tx_flush_i[i])
`ifdef USBF_FIFO_LEVEL_EN
            , .level   (tx_lvl)
`endif
        );

        assign bus.mem_ep_rx_full_o[i]           = rx_full;
        assign bus.csr_ep_rx_empty_o[i]          = rx_empty;
        assign bus.csr_ep_rx_data_o[i*DW +: DW]  = rx_head;
        assign bus.csr_ep_tx_full_o[i]           = tx_full;
        assign bus.mem_ep_tx_empty_o[i]          = tx_empty;
        assign bus.mem_ep_tx_data_o[i*DW +: DW]  = tx_head;
`ifdef USBF_FIFO_LEVEL_EN
        assign bus.csr_ep_rx_level_o[i*LW +: LW] = rx_lvl;
        assign bus.csr_ep_tx_level_o[i*LW +: LW] = tx_lvl;
`endif
    end

endmodule

// File: doc/usbf_ep_fifo.md
Name: usbf_ep_fifo

Overview:
- Endpoint FIFO memory for all endpoints: one RX FIFO and one TX FIFO per endpoint, all on phy_clk_i.
- The endpoint side (the write end of RX, read end of TX) connects to the EPU mem_ep_* ports.
- The CSR side drains each RX FIFO (CPU reads) and fills each TX FIFO (CPU writes).
- Storage is a first-word-fall-through (FWFT) register array. Implemented as a generate loop of 2*`USB_EP_NUM instances of one sync FIFO sub-module.

Parameters:
- DEPTH, 64, entries per FIFO; power of two, 2..256.
- DW, `USB_EP0_DATA_DATA_W (8), data width per entry.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- phy_clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- mem_ep_data_wt_req_i  in  N  RX push per endpoint (N=`USB_EP_NUM).
- mem_ep_rx_data_i  in  DW*N  RX push data; endpoint i in slice [i*DW +: DW].
- mem_ep_rx_full_o  out  N  RX FIFO full.
- mem_ep_data_rd_req_i  in  N  TX pop per endpoint.
- mem_ep_tx_data_o  out  DW*N  TX head data (FWFT).
- mem_ep_tx_empty_o  out  N  TX FIFO empty.
- csr_ep_rx_rd_i  in  N  CPU RX pop strobe.
- csr_ep_rx_data_o  out  DW*N  RX head data (FWFT).
- csr_ep_rx_empty_o  out  N  RX FIFO empty.
- csr_ep_rx_flush_i  in  N  RX flush.
- csr_ep_tx_wr_i  in  N  CPU TX push strobe.
- csr_ep_tx_data_i  in  DW*N  TX push data.
- csr_ep_tx_full_o  out  N  TX FIFO full.
- csr_ep_tx_flush_i  in  N  TX flush.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous assert, synchronous deassert by the system; no internal synchroniser.
- Reset values:
  - All read/write pointers = 0 and counts = 0.
  - *_empty_o = 1, *_full_o = 0.
  - Data outputs = 0. The storage array is not reset, but head data is forced to 0 while empty.
- Per-FIFO state: wr_ptr and rd_ptr, AW bits each, wrap modulo DEPTH. count is AW+1 bits, range 0..DEPTH.
- Flags: empty = (count==0), full = (count==DEPTH). Both are registered, derived from next-state count, so they are valid in the cycle after the update.
- Push (wt_req / tx_wr):
  - Accepted when !full, or when full and a pop occurs in the same cycle.
  - An accepted push writes mem[wr_ptr] and increments wr_ptr.
  - A push while full with no pop is dropped silently. Pointers and count are unchanged.
- Pop (rd_req / rx_rd):
  - Accepted when !empty; increments rd_ptr.
  - A pop while empty is ignored.
  - Head data = mem[rd_ptr], combinational from the array (FWFT). A new head is visible the cycle after the pop.
- Simultaneous push and pop:
  - Not empty and not full: both proceed, count unchanged.
  - Empty: push only, count goes 0 to 1.
  - Full: both proceed, count stays at DEPTH.
- Write-to-read latency: data pushed at cycle t is visible on head data and empty=0 at t+1.
- Flush (rx_flush / tx_flush):
  - Sets wr_ptr = rd_ptr = count = 0 at the next edge.
  - Takes priority over any push or pop in the same cycle; both are discarded.
  - Flush held high keeps the FIFO empty.
- Endpoints are fully independent. No cross-endpoint arbitration; the sub-module has no shared state.

Optional Feature:
- Macro: USBF_FIFO_LEVEL_EN.
- Defined: adds output ports csr_ep_rx_level_o and csr_ep_tx_level_o, each (AW+1)*N wide, carrying the registered count per FIFO for CSR status.
- Undefined: the ports do not exist and the counts remain internal. Behaviour is otherwise identical.

Decomposition:
- Shared definitions in usbf_cfg_defs.v: `USB_EP_NUM, `USB_EP0_DATA_DATA_W, plus a new `USB_EP_FIFO_DEPTH (default 64) used as the DEPTH default.
- One natural sub-module: usbf_sync_fifo, a single FWFT FIFO with ports push, push_data, full, pop, pop_data, empty, flush and optional level. usbf_ep_fifo instantiates it twice per endpoint in the generate loop.

Test Plan:
- Reset: assert rstn_i mid-traffic with EP0 RX holding 5 entries -> immediately empty_o=1, full_o=0, data_o=0. After release, a push of 0xA5 -> csr_ep_rx_data_o[7:0]=0xA5 one cycle later.
- Fill/overflow: DEPTH=64, push 0x00..0x3F to EP1 TX, then push 0xFF -> full_o=1 after the 64th push. 0xFF is dropped, and 64 pops return 0x00..0x3F in order, then empty_o=1.
- Underflow/wrap: push 40, pop 40, push 40, pop 40 on EP0 RX -> data sequence intact across the pointer wrap. An extra pop while empty leaves empty_o=1 and the pointers unchanged.
- Simultaneous push+pop: at full, push 0x77 with a pop in the same cycle -> full_o stays 1 and 0x77 is the last entry read. At empty, the same -> count=1, head=0x77.
- Flush priority: EP2 TX holds 10 entries; assert tx_flush with tx_wr(0x11) and rd_req in the same cycle -> next cycle empty_o=1, and 0x11 is absent from later pops.
- Independence: with USBF_FIFO_LEVEL_EN defined, push 3 to EP0 RX and 7 to EP1 TX concurrently -> levels read 3 and 7, and all other FIFOs read 0.
